if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 139 +++++++++++++
 tb/tb_if_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: one-outstanding imem request FSM, fetch queue, IF/ID register
// Optional IF_FETCH_BYPASS_EN: a response meeting an empty, unstalled queue goes straight into IF/ID.
module if_fetch #(
  parameter int          QDEPTH = 2,
  parameter logic [31:0] NOP    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        ctrl_resolve,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        pc_write,
  output logic [31:0] cur_inst,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [31:0]   req_pc;
  logic          hold;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          q_empty, q_full;
  logic          deliver, bypass, push, pop, is_ctrl;
  logic [6:0]    opcode;

  assign q_empty   = (count == '0);
  assign q_full    = (count == QFULL);
  assign imem_addr = pc_in;
  assign pc_write  = imem_req & imem_gnt;

  // A response that lands together with a flush is dropped, never delivered.
  assign deliver = (state == S_WAIT) & imem_rvalid & ~flush;
  assign opcode  = imem_rdata[6:0];
  assign is_ctrl = (opcode == 7'b1101111) | (opcode == 7'b1100111) | (opcode == 7'b1100011);

`ifdef IF_FETCH_BYPASS_EN
  assign bypass = deliver & q_empty & ~stall;
`else
  assign bypass = 1'b0;
`endif

  assign push = deliver & ~bypass;
  assign pop  = ~flush & ~stall & ~q_empty;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      S_IDLE: begin
        imem_req = rst_n & ~q_full & ~hold & ~flush;
        if (imem_req && imem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)  state_nxt = S_IDLE;
        else if (flush)   state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (imem_rvalid)  state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_pc     <= '0;
      hold       <= 1'b0;
      cur_inst   <= NOP;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_inst  <= NOP;
    end else begin
      state <= state_nxt;
      if (pc_write) req_pc <= imem_addr;

      // Control transfers park fetch until the later stage resolves or redirects.
      if (flush || ctrl_resolve)  hold <= 1'b0;
      else if (deliver && is_ctrl) hold <= 1'b1;

      if (flush)        cur_inst <= NOP;
      else if (deliver) cur_inst <= imem_rdata;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end

      if (flush) begin
        ifid_valid <= 1'b0;
        ifid_inst  <= NOP;
      end else if (!stall) begin
        if (!q_empty) begin
          ifid_valid <= 1'b1;
          ifid_pc    <= q_pc[rd_ptr];
          ifid_inst  <= q_inst[rd_ptr];
        end else if (bypass) begin
          ifid_valid <= 1'b1;
          ifid_pc    <= req_pc;
          ifid_inst  <= imem_rdata;
        end else begin
          ifid_valid <= 1'b0;
          ifid_inst  <= NOP;
        end
      end
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for if_fetch: directed scenarios plus randomized traffic
// Honours IF_FETCH_BYPASS_EN for the expected first-load latency.
module tb_if_fetch;
  localparam int          QDEPTH = 2;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef IF_FETCH_BYPASS_EN
  localparam int LOAD_LAT = 1;
`else
  localparam int LOAD_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, ctrl_resolve, imem_gnt, imem_rvalid;
  logic [31:0] pc_in, imem_rdata;
  logic        imem_req, pc_write, ifid_valid;
  logic [31:0] imem_addr, cur_inst, ifid_pc, ifid_inst;

  always #5 clk = ~clk;

  if_fetch #(.QDEPTH(QDEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .stall(stall), .flush(flush),
    .ctrl_resolve(ctrl_resolve), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_write(pc_write), .cur_inst(cur_inst), .ifid_valid(ifid_valid),
    .ifid_pc(ifid_pc), .ifid_inst(ifid_inst)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mem [64];
  bit          out_pending, out_killed, stray;
  int          out_delay, next_delay, cyc, n_writes;
  logic [31:0] out_addr, exp_cur;
  logic        exp_hold;
  logic        req_s, wr_s;
  logic [31:0] addr_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_word(input bit allow_ctrl);
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 7);
    if (allow_ctrl && r == 0)      w[6:0] = 7'b1101111;
    else if (allow_ctrl && r == 1) w[6:0] = 7'b1100011;
    else if (allow_ctrl && r == 2) w[6:0] = 7'b1100111;
    else                           w[6:0] = 7'b0010011;
    return w;
  endfunction

  // One clock of the memory/PC-register environment plus the fetch-level model.
  task automatic tick();
    logic        dlv, ctrl_op;
    logic [31:0] dword;
    imem_rvalid = stray || (out_pending && out_delay == 0);
    imem_rdata  = (imem_rvalid && !stray) ? mem[out_addr[7:2]] : $urandom;
    dword = imem_rdata;
    @(negedge clk);
    req_s  = imem_req;
    wr_s   = pc_write;
    addr_s = imem_addr;
    chk("imem_req", req_s, rst_n && !out_pending && !exp_hold && !flush && exp_q.size() < QDEPTH);
    chk("pc_write", wr_s, req_s && imem_gnt);
    if (req_s) chk("imem_addr", addr_s, pc_in);
    dlv = 1'b0;
    if (!rst_n) begin
      out_pending = 0;
      out_killed  = 0;
      exp_q.delete();
    end else begin
      if (flush) exp_q.delete();
      if (imem_rvalid && !stray) begin
        dlv = !out_killed && !flush;
        if (dlv) exp_q.push_back({out_addr, dword});
        out_pending = 0;
        out_killed  = 0;
      end else if (out_pending) begin
        if (flush) out_killed = 1;
        out_delay--;
      end
      if (wr_s) begin
        out_pending = 1;
        out_killed  = 0;
        out_addr    = addr_s;
        out_delay   = next_delay;
        n_writes++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      exp_hold = 1'b0;
      exp_cur  = NOP;
    end else begin
      if (flush)    exp_cur = NOP;
      else if (dlv) exp_cur = dword;
      ctrl_op = dword[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011};
      if (flush || ctrl_resolve) exp_hold = 1'b0;
      else if (dlv && ctrl_op)   exp_hold = 1'b1;
    end
    chk("cur_inst", cur_inst, exp_cur);
    if (wr_s) pc_in = pc_in + 32'd4;
  endtask

  task automatic quiesce();
    int k;
    imem_gnt = 0; stall = 0; flush = 0; ctrl_resolve = 0;
    k = 0;
    while ((out_pending || exp_q.size() != 0) && k < 20) begin
      tick();
      k++;
    end
    tick();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin : monitor
    logic        p_stall, p_flush, p_rst;
    logic [63:0] e;
    p_stall = stall;
    p_flush = flush;
    p_rst   = rst_n;
    #1;
    if (p_rst && rst_n) begin
      if (p_flush) begin
        chk("flush_ifid_valid", ifid_valid, 0);
        chk("flush_ifid_inst", ifid_inst, NOP);
      end else if (!p_stall && ifid_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_load: got pc %h inst %h, required no load", ifid_pc, ifid_inst);
        end else begin
          e = exp_q.pop_front();
          chk("ifid_pc", ifid_pc, e[63:32]);
          chk("ifid_inst", ifid_inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int          e0, lat, nw0;
    bit          seen;
    logic        v0;
    logic [31:0] p0, i0;
    rst_n = 0; pc_in = 0; stall = 0; flush = 0; ctrl_resolve = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    out_pending = 0; out_killed = 0; stray = 0; out_delay = 0; next_delay = 0;
    out_addr = 0; exp_hold = 0; exp_cur = NOP; cyc = 0; n_writes = 0;
    for (int i = 0; i < 64; i++) mem[i] = rand_word(0);
    mem[0] = 32'h00500093;
    mem[1] = 32'h00100113;
    mem[2] = 32'h0000006F;
    tick();
    tick();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_cur_inst", cur_inst, NOP);
    chk("rst_ifid_valid", ifid_valid, 0);
    chk("rst_ifid_pc", ifid_pc, 0);
    chk("rst_ifid_inst", ifid_inst, NOP);

    // Back-to-back fetches after reset, then jal at PC 8 parks fetch.
    rst_n = 1; imem_gnt = 1; next_delay = 0; e0 = -1; seen = 0; lat = -1;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (wr_s && addr_s == 0 && e0 < 0) e0 = cyc;
      if (ifid_valid && !seen) begin
        seen = 1;
        lat  = cyc - e0;
      end
    end
    chk("first_load_latency", seen ? lat : -1, LOAD_LAT);
    repeat (8) tick();
    chk("fetch_count_before_hold", n_writes, 3);
    chk("jal_cur_inst", cur_inst, 32'h0000006F);
    chk("hold_req_low", req_s, 0);
    repeat (4) tick();
    chk("hold_no_new_fetch", n_writes, 3);
    ctrl_resolve = 1;
    tick();
    ctrl_resolve = 0;
    tick();
    chk("resume_req", req_s, 1);
    chk("resume_addr", addr_s, 32'd12);

    // Stall fills the queue, then drains in order.
    quiesce();
    v0 = ifid_valid; p0 = ifid_pc; i0 = ifid_inst; nw0 = n_writes;
    stall = 1; imem_gnt = 1; next_delay = 0;
    repeat (6) tick();
    chk("stall_req_drop", req_s, 0);
    chk("stall_fetches", n_writes - nw0, QDEPTH);
    chk("stall_ifid_valid", ifid_valid, v0);
    chk("stall_ifid_pc", ifid_pc, p0);
    chk("stall_ifid_inst", ifid_inst, i0);
    quiesce();

    // Flush while waiting; late response must be discarded.
    mem[pc_in[7:2]] = 32'hDEADBEEF;
    imem_gnt = 1; next_delay = 2;
    tick();
    chk("flush_wait_grant", wr_s, 1);
    imem_gnt = 0; flush = 1; pc_in = 32'h40;
    tick();
    flush = 0;
    tick();
    tick();
    tick();
    chk("drain_ifid_valid", ifid_valid, 0);
    chk("drain_cur_inst", cur_inst, NOP);
    imem_gnt = 1; next_delay = 0;
    tick();
    chk("redirect_req", req_s, 1);
    chk("redirect_addr", addr_s, 32'h40);

    // Flush coincident with the response.
    quiesce();
    imem_gnt = 1; next_delay = 0;
    tick();
    flush = 1; pc_in = 32'h80;
    tick();
    flush = 0;
    chk("coflush_cur_inst", cur_inst, NOP);
    tick();
    chk("coflush_idle_req", req_s, 1);
    chk("coflush_addr", addr_s, 32'h80);

    // Reset in WAIT, then a stray response.
    quiesce();
    imem_gnt = 1; next_delay = 3;
    tick();
    imem_gnt = 0;
    tick();
    rst_n = 0;
    #1;
    chk("arst_imem_req", imem_req, 0);
    chk("arst_pc_write", pc_write, 0);
    chk("arst_cur_inst", cur_inst, NOP);
    chk("arst_ifid_valid", ifid_valid, 0);
    chk("arst_ifid_pc", ifid_pc, 0);
    chk("arst_ifid_inst", ifid_inst, NOP);
    tick();
    rst_n = 1; stray = 1;
    tick();
    stray = 0;
    tick();
    tick();
    chk("stray_ifid_valid", ifid_valid, 0);

    // Randomized traffic.
    quiesce();
    ctrl_resolve = 1;
    tick();
    ctrl_resolve = 0;
    for (int i = 0; i < 64; i++) mem[i] = rand_word(1);
    for (int n = 0; n < 400; n++) begin
      imem_gnt     = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      ctrl_resolve = !out_pending && ($urandom_range(0, 3) == 0);
      next_delay   = $urandom_range(0, 2);
      if (flush) pc_in = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      tick();
    end
    quiesce();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
